// File: rtl/sequencer_pkg.sv
// Shared types and constants for the opcode sequencer.
// Opcode layout: [19:16] operation, [15:8] operand A, [7:0] operand B.
package sequencer_pkg;

  localparam int OPW = 20;

  localparam int OP_HI = 19;
  localparam int OP_LO = 16;

  localparam logic [3:0] OP_NOP = 4'b0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_e;

endpackage

// File: rtl/opcode_fifo.sv
// Opcode queue: storage, wrapping pointers and an occupancy count.
// The head is read combinationally from the read pointer.
module opcode_fifo
  import sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = OPW,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head,
  output logic [CW-1:0] count,
  output logic         full
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] wr_ptr_d;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; only slots below count are ever read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/opcode_sequencer.sv
// Issues queued opcodes to an executor one at a time, with a one-cycle
// zero gap after each Done; NOP entries are consumed silently in IDLE.
module opcode_sequencer
  import sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OPW = sequencer_pkg::OPW,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic           Clock,
  input  logic           ResetN,
  input  logic           PushValid,
  input  logic [OPW-1:0] PushOp,
  output logic           PushReady,
  input  logic           Flush,
  output logic [OPW-1:0] OpCode,
  input  logic           Done,
  output logic           Busy,
  output logic [CW-1:0]  Count,
  output logic           Overflow
);

  state_e         state_q;
  state_e         state_d;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] op_d;
  logic           ovf_q;
  logic           ovf_d;

  logic [OPW-1:0] head;
  logic           full;
  logic           pop;
  logic           push;
  logic           has_head;
  logic           head_nop;

  opcode_fifo #(
    .DEPTH(DEPTH),
    .W(OPW)
  ) u_fifo (
    .clk      (Clock),
    .rst_n    (ResetN),
    .push     (push),
    .pop      (pop),
    .flush    (Flush),
    .push_data(PushOp),
    .head     (head),
    .count    (Count),
    .full     (full)
  );

  assign has_head = (Count != '0);
  assign head_nop = (head[OP_HI:OP_LO] == OP_NOP);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (has_head && !Flush) begin
          pop = 1'b1;
          if (!head_nop) begin
            op_d    = head;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (Done) begin
          op_d    = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
        // A NOP head waits for IDLE so the gap stays exactly one cycle.
        if (has_head && !Flush && !head_nop) begin
          pop     = 1'b1;
          op_d    = head;
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
        op_d    = '0;
      end
    endcase
  end

  // A pop frees a slot at the same edge, so a full queue can still take a push.
  assign push  = PushValid && !Flush && (!full || pop);
  assign ovf_d = ovf_q || (PushValid && full && !pop);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ovf_q   <= ovf_d;
    end
  end

  assign OpCode    = op_q;
  assign Busy      = (state_q == S_ISSUE);
  assign Overflow  = ovf_q;
  assign PushReady = !full && !Flush;

endmodule
